cacheline_adaptor: RTL

Bridges the cache's single-beat, full-line interface to the burst-oriented physical memory port. A cache line read or write request becomes one burst transaction of BURST_LEN beats on the memory side. Incoming beats are assembled into a line, and outgoing line data is sliced into beats. The block sits between the last-level cache and physical memory (the burst memory model in simulation).

---
 rtl/adaptor_pkg.sv | 26 ++
 rtl/line_burst_buffer.sv | 77 +++++++
 rtl/cacheline_adaptor.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/adaptor_pkg.sv
// -----------------------------------------------------------------------------
// adaptor_pkg
// Shared types and constants for the cache-line <-> burst memory adaptor.
//   state_t      : adaptor FSM states
//   DEF_*        : default line / burst / address geometry
//   offset_bits  : number of byte-offset bits inside one cache line
// -----------------------------------------------------------------------------
package adaptor_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DEF_LINE_WIDTH = 256;
    localparam int DEF_BURST_LEN  = 4;
    localparam int DEF_ADDR_WIDTH = 32;

    // Byte-offset bits of a line: the low address bits dropped for alignment.
    function automatic int offset_bits(input int line_width);
        return $clog2(line_width / 8);
    endfunction

endpackage

// File: rtl/line_burst_buffer.sv
// -----------------------------------------------------------------------------
// line_burst_buffer
// Holds one cache line and the beat counter that walks it.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   i_load       : load i_line into the buffer (start of a write)
//   i_line       : full line from the cache
//   i_capture    : store i_burst into the slice selected by the beat counter
//   i_advance    : increment the beat counter (wraps after the last beat)
//   i_clear      : force the beat counter to 0
//   i_burst      : read beat from memory
//   o_burst      : buffer slice selected by the beat counter (write beat)
//   o_assembled  : buffer with the current slice replaced by i_burst
//   o_beat       : current beat index
// -----------------------------------------------------------------------------
module line_burst_buffer
    import adaptor_pkg::*;
#(
    parameter  int LINE_WIDTH  = DEF_LINE_WIDTH,
    parameter  int BURST_LEN   = DEF_BURST_LEN,
    localparam int BURST_WIDTH = LINE_WIDTH / BURST_LEN,
    localparam int BEAT_WIDTH  = $clog2(BURST_LEN)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_load,
    input  logic [LINE_WIDTH-1:0]  i_line,
    input  logic                   i_capture,
    input  logic                   i_advance,
    input  logic                   i_clear,
    input  logic [BURST_WIDTH-1:0] i_burst,
    output logic [BURST_WIDTH-1:0] o_burst,
    output logic [LINE_WIDTH-1:0]  o_assembled,
    output logic [BEAT_WIDTH-1:0]  o_beat
);

    logic [LINE_WIDTH-1:0] r_line;
    logic [BEAT_WIDTH-1:0] r_beat;

    // Constant-offset decode per beat keeps both the write-in slice and the
    // output mux free of variable part-selects.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        o_assembled = r_line;
        o_burst     = '0;
        for (int b = 0; b < BURST_LEN; b++) begin
            if (r_beat == BEAT_WIDTH'(b)) begin
                o_assembled[b*BURST_WIDTH +: BURST_WIDTH] = i_burst;
                o_burst = r_line[b*BURST_WIDTH +: BURST_WIDTH];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    // NOTE: the line register is reset so burst_o reads as zero out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_line <= '0;
            r_beat <= '0;
        end else begin
            if (i_load) begin
                r_line <= i_line;
            end else if (i_capture) begin
                r_line <= o_assembled;
            end

            if (i_clear) begin
                r_beat <= '0;
            end else if (i_advance) begin
                r_beat <= r_beat + BEAT_WIDTH'(1);
            end
        end
    end

    assign o_beat = r_beat;

endmodule

// File: rtl/cacheline_adaptor.sv
// -----------------------------------------------------------------------------
// cacheline_adaptor
// Turns one full-line cache read/write request into a BURST_LEN-beat burst on
// the physical memory port, assembling read beats into a line and slicing the
// write line into beats.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   line_i     : write line from the cache
//   line_o     : last line read from memory (held until the next read completes)
//   address_i  : cache request byte address
//   read_i     : cache line read request, held until resp_o
//   write_i    : cache line write request, held until resp_o (wins over read_i)
//   resp_o     : one-cycle completion pulse to the cache
//   burst_i    : read beat from memory
//   burst_o    : write beat to memory (buffer slice at the current beat)
//   address_o  : line-aligned memory address
//   read_o     : memory read strobe
//   write_o    : memory write strobe
//   resp_i     : memory beat valid / accepted
//   err_o      : sticky protocol-violation flag, cleared only by rst
// -----------------------------------------------------------------------------
module cacheline_adaptor
    import adaptor_pkg::*;
#(
    parameter  int CACHE_LINE_WIDTH = DEF_LINE_WIDTH,
    parameter  int BURST_LEN        = DEF_BURST_LEN,
    parameter  int ADDR_WIDTH       = DEF_ADDR_WIDTH,
    localparam int BURST_WIDTH      = CACHE_LINE_WIDTH / BURST_LEN,
    localparam int OFFSET_BITS      = offset_bits(CACHE_LINE_WIDTH),
    localparam int BEAT_WIDTH       = $clog2(BURST_LEN)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [CACHE_LINE_WIDTH-1:0] line_i,
    output logic [CACHE_LINE_WIDTH-1:0] line_o,
    input  logic [ADDR_WIDTH-1:0]       address_i,
    input  logic                        read_i,
    input  logic                        write_i,
    output logic                        resp_o,
    input  logic [BURST_WIDTH-1:0]      burst_i,
    output logic [BURST_WIDTH-1:0]      burst_o,
    output logic [ADDR_WIDTH-1:0]       address_o,
    output logic                        read_o,
    output logic                        write_o,
    input  logic                        resp_i,
    output logic                        err_o
);

    state_t                      r_state;
    logic                        r_read;
    logic                        r_write;
    logic                        r_resp;
    logic                        r_err;
    logic [ADDR_WIDTH-1:0]       r_address;
    logic [CACHE_LINE_WIDTH-1:0] r_line_out;

    logic                        w_load;
    logic                        w_capture;
    logic                        w_advance;
    logic                        w_clear;
    logic                        w_last_beat;
    logic [BEAT_WIDTH-1:0]       w_beat;
    logic [CACHE_LINE_WIDTH-1:0] w_assembled;
    logic [ADDR_WIDTH-1:0]       w_aligned_address;
    logic                        w_unused_offset;

    assign w_aligned_address = {address_i[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
    // Byte-offset bits are intentionally dropped by the alignment above.
    assign w_unused_offset   = ^address_i[OFFSET_BITS-1:0];

    // Buffer controls: decoded from the current state so they act on the
    // same edge the FSM makes its decision.
    assign w_load      = (r_state == IDLE) && write_i;
    assign w_capture   = (r_state == READ) && resp_i;
    assign w_advance   = ((r_state == READ) || (r_state == WRITE)) && resp_i;
    assign w_clear     = (r_state == DONE);
    assign w_last_beat = (w_beat == BEAT_WIDTH'(BURST_LEN - 1));

    line_burst_buffer #(
        .LINE_WIDTH (CACHE_LINE_WIDTH),
        .BURST_LEN  (BURST_LEN)
    ) u_buffer (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_load),
        .i_line      (line_i),
        .i_capture   (w_capture),
        .i_advance   (w_advance),
        .i_clear     (w_clear),
        .i_burst     (burst_i),
        .o_burst     (burst_o),
        .o_assembled (w_assembled),
        .o_beat      (w_beat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_read     <= 1'b0;
            r_write    <= 1'b0;
            r_resp     <= 1'b0;
            r_err      <= 1'b0;
            r_address  <= '0;
            r_line_out <= '0;
        end else begin
            r_resp <= 1'b0;

            // A beat from memory when no burst is outstanding is a protocol error.
            if (((r_state == IDLE) || (r_state == DONE)) && resp_i) begin
                r_err <= 1'b1;
            end

            unique case (r_state)
                IDLE: begin
                    if (write_i) begin
                        r_address <= w_aligned_address;
                        r_write   <= 1'b1;
                        r_state   <= WRITE;
                        if (read_i) begin
                            r_err <= 1'b1;
                        end
                    end else if (read_i) begin
                        r_address <= w_aligned_address;
                        r_read    <= 1'b1;
                        r_state   <= READ;
                    end
                end
                READ: begin
                    // The final beat is not yet in the buffer, so line_o takes
                    // the assembled view that already includes it.
                    if (resp_i && w_last_beat) begin
                        r_read     <= 1'b0;
                        r_line_out <= w_assembled;
                        r_resp     <= 1'b1;
                        r_state    <= DONE;
                    end
                end
                WRITE: begin
                    if (resp_i && w_last_beat) begin
                        r_write <= 1'b0;
                        r_resp  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    // Still-held requests are ignored here; the cache is
                    // seeing resp_o during this cycle.
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign line_o    = r_line_out;
    assign resp_o    = r_resp;
    assign address_o = r_address;
    assign read_o    = r_read;
    assign write_o   = r_write;
    assign err_o     = r_err;

endmodule
